// File: rtl/cache_access_ctrl.sv
// cache_access_ctrl: lookup sequencing controller for an 8-way set-associative
// cache. Arbitrates CPU and snoop requests, strobes the tag-compare stage,
// picks a per-set tree pseudo-LRU victim on a CPU miss, writes back a dirty
// victim, requests the line fill and returns a one-cycle response.
//
// Optional build macro: CACHE_CTRL_RR_ARB_EN
//   defined   -> round-robin between CPU and snoop when both are valid
//   undefined -> snoop always wins over CPU
module cache_access_ctrl #(
  parameter int WAYS_REP = 3,
  parameter int INDEX    = 4,
  parameter int TAG_W    = 12
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                cpu_req_valid,
  input  logic                cpu_req_write,
  input  logic [INDEX-1:0]    cpu_req_index,
  input  logic [TAG_W-1:0]    cpu_req_tag,
  output logic                cpu_req_ready,
  input  logic                snp_req_valid,
  input  logic [INDEX-1:0]    snp_req_index,
  input  logic [TAG_W-1:0]    snp_req_tag,
  output logic                snp_req_ready,
  output logic                lkp_valid,
  output logic [INDEX-1:0]    lkp_index,
  output logic [TAG_W-1:0]    lkp_tag,
  input  logic                lkp_hit,
  input  logic [WAYS_REP-1:0] lkp_way,
  output logic [WAYS_REP-1:0] victim_way,
  input  logic                victim_dirty,
  output logic                mem_wr_req,
  output logic                mem_rd_req,
  input  logic                mem_ack,
  output logic                fill_en,
  output logic [WAYS_REP-1:0] fill_way,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [WAYS_REP-1:0] resp_way,
  output logic                resp_snoop
);

  localparam int SETS = 1 << INDEX;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRBACK, FILL, RESP} state_t;

  state_t             r_state;
  logic               r_snoop;
  logic               r_write;
  logic [INDEX-1:0]   r_index;
  logic [TAG_W-1:0]   r_tag;
  logic               r_lkp_valid;
  logic [2:0]         r_victim;
  logic               r_mem_wr_req;
  logic               r_mem_rd_req;
  logic               r_resp_valid;
  logic               r_resp_hit;
  logic [2:0]         r_resp_way;
  logic               r_resp_snoop;
  logic [6:0]         r_plru [SETS];

  logic               w_idle;
  logic               w_pick_snp;
  logic               w_grant_snp;
  logic               w_grant_cpu;
  logic [2:0]         w_victim;
  logic               w_unused_write;

  // Tree walk: root picks the half, the next level the quarter, the leaf the way.
  function automatic logic [2:0] plru_victim(input logic [6:0] b);
    logic v2, v1, v0;
    v2 = b[0];
    v1 = v2 ? b[2] : b[1];
    case ({v2, v1})
      2'd0:    v0 = b[3];
      2'd1:    v0 = b[4];
      2'd2:    v0 = b[5];
      default: v0 = b[6];
    endcase
    return {v2, v1, v0};
  endfunction

  // Point every node on the path to way w away from w; off-path nodes hold.
  function automatic logic [6:0] plru_touch(input logic [6:0] b, input logic [2:0] w);
    logic [6:0] n;
    n    = b;
    n[0] = ~w[2];
    if (w[2]) n[2] = ~w[1];
    else      n[1] = ~w[1];
    case (w[2:1])
      2'd0:    n[3] = ~w[0];
      2'd1:    n[4] = ~w[0];
      2'd2:    n[5] = ~w[0];
      default: n[6] = ~w[0];
    endcase
    return n;
  endfunction

  // Requests are only taken in IDLE and never while reset is being sampled.
  assign w_idle = (r_state == IDLE) && !rstb;

`ifdef CACHE_CTRL_RR_ARB_EN
  logic r_last_snp;

  // Remember the most recent grant so a contested cycle goes to the other source.
  always_ff @(posedge clk) begin
    if (rstb)                          r_last_snp <= 1'b0;
    else if (w_grant_snp | w_grant_cpu) r_last_snp <= w_grant_snp;
  end

  assign w_pick_snp = snp_req_valid & (~cpu_req_valid | ~r_last_snp);
`else
  assign w_pick_snp = snp_req_valid;
`endif

  assign w_grant_snp = w_idle & w_pick_snp;
  assign w_grant_cpu = w_idle & cpu_req_valid & ~w_pick_snp;
  assign w_victim    = plru_victim(r_plru[r_index]);

  // The write flag is captured with the request but nothing downstream uses it yet.
  assign w_unused_write = r_write;

  // Main sequencer: request capture, lookup decision, memory handshakes, response.
  always_ff @(posedge clk) begin
    // NOTE: every register here, the pLRU table included, uses <= so all state
    // advances together on the edge; the table is cleared in reset because the
    // victim choice after reset must be deterministic (way 0 everywhere).
    if (rstb) begin
      r_state      <= IDLE;
      r_snoop      <= 1'b0;
      r_write      <= 1'b0;
      r_index      <= '0;
      r_tag        <= '0;
      r_lkp_valid  <= 1'b0;
      r_victim     <= '0;
      r_mem_wr_req <= 1'b0;
      r_mem_rd_req <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
      r_resp_snoop <= 1'b0;
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_snp | w_grant_cpu) begin
            r_snoop     <= w_grant_snp;
            r_write     <= w_grant_snp ? 1'b0 : cpu_req_write;
            r_index     <= w_grant_snp ? snp_req_index : cpu_req_index;
            r_tag       <= w_grant_snp ? snp_req_tag : cpu_req_tag;
            r_lkp_valid <= 1'b1;
            r_state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_lkp_valid <= 1'b0;
          if (lkp_hit) begin
            if (!r_snoop) r_plru[r_index] <= plru_touch(r_plru[r_index], lkp_way);
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b1;
            r_resp_way   <= lkp_way;
            r_resp_snoop <= r_snoop;
            r_state      <= RESP;
          end else if (r_snoop) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= '0;
            r_resp_snoop <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_victim <= w_victim;
            if (victim_dirty) begin
              r_mem_wr_req <= 1'b1;
              r_state      <= WRBACK;
            end else begin
              r_mem_rd_req <= 1'b1;
              r_state      <= FILL;
            end
          end
        end
        WRBACK: begin
          if (mem_ack) begin
            r_mem_wr_req <= 1'b0;
            r_mem_rd_req <= 1'b1;
            r_state      <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            r_mem_rd_req    <= 1'b0;
            r_plru[r_index] <= plru_touch(r_plru[r_index], r_victim);
            r_resp_valid    <= 1'b1;
            r_resp_hit      <= 1'b0;
            r_resp_way      <= r_victim;
            r_resp_snoop    <= 1'b0;
            r_state         <= RESP;
          end
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_req_ready = w_grant_cpu;
  assign snp_req_ready = w_grant_snp;
  assign lkp_valid     = r_lkp_valid;
  assign lkp_index     = r_index;
  assign lkp_tag       = r_tag;
  assign victim_way    = w_victim;
  assign mem_wr_req    = r_mem_wr_req;
  assign mem_rd_req    = r_mem_rd_req;
  assign fill_en       = r_mem_rd_req & mem_ack & !rstb;
  assign fill_way      = r_victim;
  assign resp_valid    = r_resp_valid;
  assign resp_hit      = r_resp_hit;
  assign resp_way      = r_resp_way;
  assign resp_snoop    = r_resp_snoop;

endmodule

// File: doc/cache_access_ctrl.md
Name: cache_access_ctrl

Overview:
Sequencing controller for the 8-way set-associative cache lookup path. It arbitrates between CPU and snoop requests and drives the tag-compare stage, which returns hit and way combinationally. On a CPU miss it selects a victim with a per-set tree pseudo-LRU, writes the victim back if it is dirty, and requests the line fill. It sits between the request interfaces and the cache array, hit-compare logic and memory bus.

Parameters:
WAYS_REP, 3, way-select width; only 3 (8 ways) is supported.
INDEX, 4, set-index width; number of sets is 2**INDEX.
TAG_W, 12, tag width.

Ports:
clk  in  1  clock.
rstb  in  1  reset; synchronous, active-high.
cpu_req_valid  in  1  CPU request present.
cpu_req_write  in  1  1 = write, 0 = read.
cpu_req_index  in  INDEX  CPU set index.
cpu_req_tag  in  TAG_W  CPU tag.
cpu_req_ready  out  1  CPU request accepted this cycle.
snp_req_valid  in  1  snoop request present.
snp_req_index  in  INDEX  snoop set index.
snp_req_tag  in  TAG_W  snoop tag.
snp_req_ready  out  1  snoop request accepted this cycle.
lkp_valid  out  1  lookup strobe to the hit-compare stage.
lkp_index  out  INDEX  registered index of the lookup.
lkp_tag  out  TAG_W  registered tag of the lookup.
lkp_hit  in  1  compare hit; valid in the same cycle as lkp_valid.
lkp_way  in  WAYS_REP  hitting way; valid when lkp_hit=1.
victim_way  out  WAYS_REP  pLRU victim for the current set.
victim_dirty  in  1  dirty bit of victim_way; read combinationally.
mem_wr_req  out  1  writeback request, level.
mem_rd_req  out  1  line-fill request, level.
mem_ack  in  1  single-cycle completion of the pending mem request.
fill_en  out  1  one-cycle array write strobe.
fill_way  out  WAYS_REP  way being filled.
resp_valid  out  1  one-cycle response strobe.
resp_hit  out  1  the request hit.
resp_way  out  WAYS_REP  hit way, or filled way on a miss.
resp_snoop  out  1  1 = response belongs to the snoop request.

Behaviour:
- FSM states: IDLE, LOOKUP, WRBACK, FILL, RESP. Reset state is IDLE.
- Reset:
  - All outputs reset to 0 and all pLRU bits clear to 0.
  - An in-flight request is dropped with no response.
  - mem_*_req deasserts on the cycle after reset is sampled.
- IDLE:
  - Ready is asserted only in IDLE, and to at most one requester.
  - Default arbitration: snoop has priority over CPU.
  - On acceptance, capture index, tag, write flag and source, then go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - lkp_valid=1 with the captured index and tag; lkp_hit and lkp_way are sampled this cycle.
  - Hit: go to RESP. For a CPU source only, update pLRU with lkp_way.
  - Snoop miss: go to RESP with resp_hit=0. No pLRU change and no memory traffic.
  - CPU miss: latch victim_way. If victim_dirty=1 go to WRBACK, else go to FILL.
- WRBACK: hold mem_wr_req=1 until mem_ack, then go to FILL.
- FILL:
  - Hold mem_rd_req=1 until mem_ack.
  - In the ack cycle: fill_en=1, fill_way=latched victim, update pLRU with the victim, next state RESP.
- RESP:
  - resp_valid=1 for one cycle. resp_way is the hit way or the fill way; resp_hit and resp_snoop are set to match the request.
  - Next state is IDLE.
- Latency:
  - Hit: resp_valid is asserted 2 cycles after the accept edge.
  - Clean miss: resp_valid is asserted 1 cycle after the fill ack.
- mem_ack outside WRBACK/FILL is ignored. mem_wr_req and mem_rd_req are never high together.
- pLRU: 7 bits b[6:0] per set; a bit value of 0 means the victim lies in the lower half.
  - Victim: v2=b0, v1=b[1+v2], v0=b[3+{v2,v1}].
  - Update on access to way w: b0=~w2, b[1+w2]=~w1, b[3+{w2,w1}]=~w0. Other bits hold.
  - victim_way is combinational from the pLRU entry of lkp_index (captured index).
- Only the accessed set's pLRU entry changes. Hit and fill updates never coincide.

Optional Feature:
CACHE_CTRL_RR_ARB_EN
- Defined: round-robin arbitration when both requesters are valid in IDLE. The source opposite to the last-granted one wins; the last grant resets to CPU, so a snoop wins first.
- Undefined: fixed snoop priority; a CPU request can starve under continuous snoop traffic.

Test Plan:
- Reset, then CPU read idx 2 tag 0x0A5 with lkp_hit=1, way 5 -> resp_valid 2 cycles after accept, resp_hit=1, resp_way=5, no mem_*_req.
- After reset, CPU read idx 3 misses with victim_dirty=0 -> victim_way=0, mem_rd_req held until mem_ack (sent 4 cycles later), fill_en with fill_way=0, then resp_hit=0, resp_way=0. Next miss on idx 3 gives victim_way=4.
- CPU miss with victim_dirty=1 -> mem_wr_req until ack, then mem_rd_req until ack, then fill_en and resp; the two requests never overlap.
- cpu_req_valid and snp_req_valid both high in IDLE, snoop misses -> snoop granted first, resp_hit=0 with resp_snoop=1, no mem traffic, no pLRU change; CPU served next.
- Assert rstb during FILL while mem_rd_req=1 -> next cycle state is IDLE, all outputs 0, all pLRU bits 0; no resp_valid.
- With CACHE_CTRL_RR_ARB_EN, both requesters held valid for 4 transactions -> grants go snoop, CPU, snoop, CPU; without it -> snoop on all 4.
